// File: rtl/unary_add_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : unary_add_n                                                   |
// | Brief    : Multi-lane unary accumulator (wrap or saturate) + serial drain |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module unary_add_n #(
  parameter int LANES    = 2,
  parameter int CNT_W    = 4,
  parameter int LIMIT    = 15,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             read_or_write,
  input  logic [LANES-1:0] din,
  output logic             dout,
  output logic             C,
  output logic             sat,
  output logic [CNT_W-1:0] count_o,
  output logic             drain_done
);

  localparam int                PC_W    = $clog2(LANES + 1);
  localparam int                SUM_W   = CNT_W + 1;
  localparam logic [SUM_W-1:0]  LIMIT_S = SUM_W'(LIMIT);
  localparam logic [SUM_W-1:0]  TOP_S   = SUM_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0]  TOP_C   = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             dout_q, dout_d;
  logic             c_q, c_d;
  logic             sat_q, sat_d;
  logic             done_q, done_d;

  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] sum_low;
  logic [CNT_W-1:0] sum_wrap;

  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) begin
      pc = pc + PC_W'(din[i]);
    end
  end

  // LANES <= LIMIT bounds sum below 2*LIMIT, so one subtraction always suffices.
  assign sum      = SUM_W'(pc) + {1'b0, count_q};
  assign sum_low  = CNT_W'(sum);
  assign sum_wrap = CNT_W'(sum - LIMIT_S);

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    dout_d  = 1'b0;
    c_d     = 1'b0;
    done_d  = 1'b0;
    if (en) begin
      if (read_or_write) begin
        sat_d = 1'b0;
        if (count_q != '0) begin
          dout_d  = 1'b1;
          count_d = count_q - CNT_W'(1);
          done_d  = (count_q == CNT_W'(1));
        end
      end else if (SAT_MODE != 0) begin
        if ((sum >= TOP_S) && (pc != '0)) begin
          count_d = TOP_C;
          if (sum > TOP_S) begin
            sat_d = 1'b1;
          end
        end else begin
          count_d = sum_low;
        end
      end else begin
        if (sum >= LIMIT_S) begin
          count_d = sum_wrap;
          c_d     = 1'b1;
        end else begin
          count_d = sum_low;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dout_q  <= 1'b0;
      c_q     <= 1'b0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      c_q     <= c_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign count_o    = count_q;
  assign dout       = dout_q;
  assign C          = c_q;
  assign sat        = sat_q;
  assign drain_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_unary_add_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_unary_add_n                                                |
// | Brief    : Directed self-checking bench: wrap, saturate and wide configs  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_unary_add_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Default config: wrap mode
  logic       en0 = 1'b0, rw0 = 1'b0;
  logic [1:0] din0 = '0;
  logic       dout0, c0, sat0, done0;
  logic [3:0] cnt0;

  // Saturating config
  logic       en1 = 1'b0, rw1 = 1'b0;
  logic [1:0] din1 = '0;
  logic       dout1, c1, sat1, done1;
  logic [3:0] cnt1;

  // Wide config
  logic       en2 = 1'b0, rw2 = 1'b0;
  logic [3:0] din2 = '0;
  logic       dout2, c2, sat2, done2;
  logic [4:0] cnt2;

  unary_add_n u_dut (
    .clk(clk), .rst_n(rst_n), .en(en0), .read_or_write(rw0), .din(din0),
    .dout(dout0), .C(c0), .sat(sat0), .count_o(cnt0), .drain_done(done0)
  );

  unary_add_n #(.SAT_MODE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en1), .read_or_write(rw1), .din(din1),
    .dout(dout1), .C(c1), .sat(sat1), .count_o(cnt1), .drain_done(done1)
  );

  unary_add_n #(.LANES(4), .CNT_W(5), .LIMIT(20)) u_wide (
    .clk(clk), .rst_n(rst_n), .en(en2), .read_or_write(rw2), .din(din2),
    .dout(dout2), .C(c2), .sat(sat2), .count_o(cnt2), .drain_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected values below are hand-computed for each vector.
  int exp_dout [5] = '{1, 1, 1, 0, 0};
  int exp_done [5] = '{0, 0, 1, 0, 0};
  int exp_cnt  [5] = '{2, 1, 0, 0, 0};
  int m_cnt    [5] = '{4, 3, 3, 3, 4};
  int m_dout   [5] = '{1, 1, 0, 0, 0};

  initial begin
    #2;
    chk("rst_count", {28'd0, cnt0}, 0);
    chk("rst_outs", {dout0, c0, sat0, done0}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap sequence: 2,4,...,14 then 0 with carry
    en0 = 1'b1; rw0 = 1'b0; din0 = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("acc_cnt", {28'd0, cnt0}, 2 * k);
      chk("acc_c", {31'd0, c0}, 0);
    end
    din0 = 2'b01; step();
    chk("wrap_cnt", {28'd0, cnt0}, 0);
    chk("wrap_c", {31'd0, c0}, 1);
    din0 = 2'b00; step();
    chk("c_clear", {31'd0, c0}, 0);
    chk("din0_hold", {28'd0, cnt0}, 0);

    // 14 + 2 wraps to 1
    din0 = 2'b11;
    for (int k = 0; k < 7; k++) step();
    chk("pre14", {28'd0, cnt0}, 14);
    step();
    chk("wrap1_cnt", {28'd0, cnt0}, 1);
    chk("wrap1_c", {31'd0, c0}, 1);
    step();
    chk("to3_cnt", {28'd0, cnt0}, 3);
    chk("to3_c", {31'd0, c0}, 0);

    // Drain from 3 for five cycles
    rw0 = 1'b1; din0 = 2'b11;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("drn_dout", {31'd0, dout0}, exp_dout[k]);
      chk("drn_done", {31'd0, done0}, exp_done[k]);
      chk("drn_cnt", {28'd0, cnt0}, exp_cnt[k]);
    end

    // Build 5, drain 2, hold 2, accumulate 10
    rw0 = 1'b0; din0 = 2'b11; step(); step();
    din0 = 2'b01; step();
    chk("to5", {28'd0, cnt0}, 5);
    for (int k = 0; k < 5; k++) begin
      en0 = (k < 2 || k == 4);
      rw0 = (k < 2);
      din0 = 2'b10;
      step();
      chk("mix_cnt", {28'd0, cnt0}, m_cnt[k]);
      chk("mix_dout", {31'd0, dout0}, m_dout[k]);
      chk("mix_done", {31'd0, done0}, 0);
    end
    en0 = 1'b0;

    // Saturate: reach 13, overflow to 14 with sticky flag
    en1 = 1'b1; rw1 = 1'b0; din1 = 2'b11;
    for (int k = 0; k < 6; k++) step();
    din1 = 2'b01; step();
    chk("sat_13", {28'd0, cnt1}, 13);
    din1 = 2'b11; step();
    chk("sat_cnt", {28'd0, cnt1}, 14);
    chk("sat_flag", {31'd0, sat1}, 1);
    chk("sat_noc", {31'd0, c1}, 0);
    din1 = 2'b01; step();
    chk("sat_hold", {28'd0, cnt1}, 14);
    chk("sat_sticky", {31'd0, sat1}, 1);
    rw1 = 1'b1; step();
    chk("sat_drn_cnt", {28'd0, cnt1}, 13);
    chk("sat_drn_flag", {31'd0, sat1}, 0);
    rw1 = 1'b0; din1 = 2'b01; step();
    chk("sat_exact_cnt", {28'd0, cnt1}, 14);
    chk("sat_exact_flag", {31'd0, sat1}, 0);
    en1 = 1'b0;

    // Wide: reach 18, add 4 wraps to 2, then reset mid-drain
    en2 = 1'b1; rw2 = 1'b0; din2 = 4'b1111;
    for (int k = 0; k < 4; k++) step();
    din2 = 4'b0011; step();
    chk("w_18", {27'd0, cnt2}, 18);
    din2 = 4'b1111; step();
    chk("w_wrap_cnt", {27'd0, cnt2}, 2);
    chk("w_wrap_c", {31'd0, c2}, 1);
    rw2 = 1'b1; step();
    chk("w_drn_cnt", {27'd0, cnt2}, 1);
    chk("w_drn_dout", {31'd0, dout2}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("w_arst_cnt", {27'd0, cnt2}, 0);
    chk("w_arst_outs", {dout2, c2, sat2, done2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rw2 = 1'b0; din2 = 4'b0000; step();
    chk("w_rel_cnt", {27'd0, cnt2}, 0);
    chk("w_rel_outs", {dout2, c2, sat2, done2}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
